nand_flash_responder: RTL and testbench

- Synthesizable NAND flash target: the device end of the F_IO/CLE/ALE/REN/WEN/RB interface driven by the NFC controller.
- Decodes command, address and data cycles and holds a small page array.
- Serves read, program, read-status and reset commands.
- Drives RB busy for parameterised clock counts.
- Used as an on-chip flash stand-in for controller/TMR bring-up and regression.

---
 rtl/nand_flash_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_nand_flash_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_flash_responder.sv
// nand_flash_responder
//   Device end of a NAND flash bus, used as an on-chip flash stand-in for
//   controller bring-up. It decodes command/address/data cycles from the
//   F_WEN strobe and holds a PAGE_BYTES x NUM_PAGES array plus a one-page
//   register. It serves read (00h), program (80h ... 10h), status (70h)
//   and reset (FFh), and pulls F_RB low for T_R / T_PROG / T_RST clocks.
//
//   Optional feature macro: NAND_WRITE_PROTECT_EN adds F_WPN (active-low
//   write protect). A protected confirm still runs the full program busy
//   time but leaves the array untouched and sets the fail bit.
//
// Ports
//   clk       single clock, strobes sampled on its rising edge
//   rst       asynchronous active-high reset
//   F_IO_IN   bus value from the pad
//   F_IO_OUT  bus value driven by the device
//   F_IO_OE   1 = device drives the bus
//   F_CLE     command latch enable
//   F_ALE     address latch enable
//   F_REN     read enable, active low
//   F_WEN     write enable, active low
//   F_RB      1 = ready, 0 = busy
//   F_WPN     write protect, active low (only with NAND_WRITE_PROTECT_EN)
//
// Handshake: a bus cycle is accepted on the synchronised rising edge of
// F_WEN; F_CLE/F_ALE/F_IO_IN are taken as they stand in that clock, so the
// controller holds them until the edge has passed the synchroniser. Read
// data appears on the synchronised F_REN falling edge and the column
// advances on its rising edge.

module nand_flash_responder #(
  parameter int PAGE_BYTES = 16,
  parameter int NUM_PAGES  = 16,
  parameter int T_R        = 8,
  parameter int T_PROG     = 20,
  parameter int T_RST      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] F_IO_IN,
  output logic [7:0] F_IO_OUT,
  output logic       F_IO_OE,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_REN,
  input  logic       F_WEN,
  output logic       F_RB
`ifdef NAND_WRITE_PROTECT_EN
  ,
  input  logic       F_WPN
`endif
);

  localparam int COL_W = $clog2(PAGE_BYTES);
  localparam int PG_W  = $clog2(NUM_PAGES);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_DIN    = 3'd2;
  localparam logic [2:0] ST_BUSY   = 3'd3;
  localparam logic [2:0] ST_DOUT   = 3'd4;
  localparam logic [2:0] ST_STATUS = 3'd5;

  // What the current busy period finishes with.
  localparam logic [1:0] K_LOAD = 2'd0;
  localparam logic [1:0] K_PROG = 2'd1;
  localparam logic [1:0] K_RST  = 2'd2;

  logic [2:0]       state;
  logic [1:0]       busy_kind;
  logic [15:0]      cnt;
  logic [COL_W-1:0] col;
  logic [PG_W-1:0]  page;
  logic             addr_n;    // 0 = next address cycle is column
  logic             prog_op;   // address phase belongs to a program
  logic             prog_ok;   // confirmed program may commit
  logic             fail;

  logic [7:0] page_reg [PAGE_BYTES];
  logic [7:0] mem      [NUM_PAGES][PAGE_BYTES];

  // Strobe synchronisers; the third flop is the previous value for edges.
  logic wen_s1, wen_s2, wen_s3;
  logic ren_s1, ren_s2, ren_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_s1 <= 1'b1; wen_s2 <= 1'b1; wen_s3 <= 1'b1;
      ren_s1 <= 1'b1; ren_s2 <= 1'b1; ren_s3 <= 1'b1;
    end else begin
      wen_s1 <= F_WEN; wen_s2 <= wen_s1; wen_s3 <= wen_s2;
      ren_s1 <= F_REN; ren_s2 <= ren_s1; ren_s3 <= ren_s2;
    end
  end

  logic wen_rise, ren_fall, ren_rise;
  logic is_cmd, is_addr, is_data, is_reset_cmd;
  logic wp_n;
  logic [7:0] status_byte;
  logic commit_now;

  assign wen_rise = wen_s2 & ~wen_s3;
  assign ren_fall = ~ren_s2 & ren_s3;
  assign ren_rise = ren_s2 & ~ren_s3;

  assign is_cmd       = wen_rise & F_CLE & ~F_ALE;
  assign is_addr      = wen_rise & ~F_CLE & F_ALE;
  assign is_data      = wen_rise & ~F_CLE & ~F_ALE;
  assign is_reset_cmd = is_cmd & (F_IO_IN == 8'hFF);

`ifdef NAND_WRITE_PROTECT_EN
  assign wp_n = F_WPN;
`else
  assign wp_n = 1'b1;
`endif

  assign status_byte = {wp_n, F_RB, 5'b0, fail};

  // A reset command arriving in the final busy clock wins over the commit.
  assign commit_now = (state == ST_BUSY) && (busy_kind == K_PROG) &&
                      (cnt == 16'd0) && prog_ok && !is_reset_cmd;

  // Array storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit_now) begin
      for (int i = 0; i < PAGE_BYTES; i++) mem[page][i] <= page_reg[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy_kind <= K_LOAD;
      cnt       <= 16'd0;
      col       <= '0;
      page      <= '0;
      addr_n    <= 1'b0;
      prog_op   <= 1'b0;
      prog_ok   <= 1'b0;
      fail      <= 1'b0;
      F_IO_OUT  <= 8'h00;
      F_IO_OE   <= 1'b0;
      F_RB      <= 1'b1;
      for (int i = 0; i < PAGE_BYTES; i++) page_reg[i] <= 8'hFF;
    end else if (is_reset_cmd) begin
      // Accepted even while busy; aborts any load or commit in flight.
      F_IO_OE   <= 1'b0;
      col       <= '0;
      state     <= ST_BUSY;
      busy_kind <= K_RST;
      cnt       <= 16'(T_RST - 1);
      F_RB      <= 1'b0;
    end else if (is_cmd && F_RB) begin
      F_IO_OE <= 1'b0;
      case (F_IO_IN)
        8'h00: begin
          state   <= ST_ADDR;
          addr_n  <= 1'b0;
          prog_op <= 1'b0;
        end
        8'h80: begin
          for (int i = 0; i < PAGE_BYTES; i++) page_reg[i] <= 8'hFF;
          fail    <= 1'b0;
          state   <= ST_ADDR;
          addr_n  <= 1'b0;
          prog_op <= 1'b1;
        end
        8'h10: begin
          if (state == ST_DIN) begin
            state     <= ST_BUSY;
            busy_kind <= K_PROG;
            cnt       <= 16'(T_PROG - 1);
            F_RB      <= 1'b0;
            prog_ok   <= wp_n;
            if (!wp_n) fail <= 1'b1;
          end
        end
        8'h70: state <= ST_STATUS;
        default: state <= ST_IDLE;
      endcase
    end else begin
      case (state)
        ST_ADDR: begin
          if (is_addr) begin
            if (!addr_n) begin
              col    <= F_IO_IN[COL_W-1:0];
              addr_n <= 1'b1;
            end else begin
              page <= F_IO_IN[PG_W-1:0];
              if (prog_op) begin
                state <= ST_DIN;
              end else begin
                state     <= ST_BUSY;
                busy_kind <= K_LOAD;
                cnt       <= 16'(T_R - 1);
                F_RB      <= 1'b0;
              end
            end
          end
        end
        ST_DIN: begin
          if (is_data) begin
            page_reg[col] <= F_IO_IN;
            col           <= col + 1'b1;
          end
        end
        ST_BUSY: begin
          // Ready rises on the same clock the state leaves BUSY.
          if (cnt == 16'd0) begin
            F_RB <= 1'b1;
            if (busy_kind == K_LOAD) begin
              for (int i = 0; i < PAGE_BYTES; i++) page_reg[i] <= mem[page][i];
              state <= ST_DOUT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_DOUT: begin
          if (ren_fall) begin
            F_IO_OUT <= page_reg[col];
            F_IO_OE  <= 1'b1;
          end else if (ren_rise) begin
            col     <= col + 1'b1;
            F_IO_OE <= 1'b0;
          end
        end
        ST_STATUS: begin
          if (ren_fall) begin
            F_IO_OUT <= status_byte;
            F_IO_OE  <= 1'b1;
          end else if (ren_rise) begin
            F_IO_OE <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_flash_responder.sv
// tb_nand_flash_responder
//   Drives the NAND bus with command/address/data/REN tasks, keeps a model
//   of the array, and checks read data through an expected-byte queue.
//   Busy lengths are measured from F_RB by an independent monitor.

module tb_nand_flash_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] F_IO_IN;
  logic [7:0] F_IO_OUT;
  logic       F_IO_OE;
  logic       F_CLE, F_ALE, F_REN, F_WEN;
  logic       F_RB;
`ifdef NAND_WRITE_PROTECT_EN
  logic       F_WPN;
`endif

  nand_flash_responder dut (
    .clk      (clk),
    .rst      (rst),
    .F_IO_IN  (F_IO_IN),
    .F_IO_OUT (F_IO_OUT),
    .F_IO_OE  (F_IO_OE),
    .F_CLE    (F_CLE),
    .F_ALE    (F_ALE),
    .F_REN    (F_REN),
    .F_WEN    (F_WEN),
    .F_RB     (F_RB)
`ifdef NAND_WRITE_PROTECT_EN
    ,
    .F_WPN    (F_WPN)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model    [16][16];
  logic [7:0] data_buf [32];
  int         run_len   = 0;
  int         last_busy = 0;

  // Length of the most recent busy window, in clocks.
  always @(negedge clk) begin
    if (!F_RB) run_len++;
    else if (run_len != 0) begin
      last_busy = run_len;
      run_len   = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_cycle(input logic cle, input logic ale, input logic [7:0] val);
    @(negedge clk);
    F_CLE = cle; F_ALE = ale; F_IO_IN = val; F_WEN = 1'b0;
    repeat (3) @(negedge clk);
    F_WEN = 1'b1;
    repeat (4) @(negedge clk);
    F_CLE = 1'b0; F_ALE = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] v);  bus_cycle(1'b1, 1'b0, v); endtask
  task automatic addr(input logic [7:0] v); bus_cycle(1'b0, 1'b1, v); endtask
  task automatic din(input logic [7:0] v);  bus_cycle(1'b0, 1'b0, v); endtask

  task automatic ren_pulse(output logic [7:0] val, output logic oe);
    @(negedge clk);
    F_REN = 1'b0;
    repeat (4) @(negedge clk);
    val = F_IO_OUT;
    oe  = F_IO_OE;
    F_REN = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300 && !F_RB; i++) @(negedge clk);
    if (!F_RB) check("rb_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic program_load(input logic [7:0] c, input logic [7:0] p, input int n);
    cmd(8'h80); addr(c); addr(p);
    for (int i = 0; i < n; i++) din(data_buf[i]);
  endtask

  // Model of a successful commit: page register starts all FFh.
  task automatic commit_model(input logic [7:0] c, input logic [7:0] p, input int n);
    logic [3:0] cc;
    cc = c[3:0];
    for (int i = 0; i < 16; i++) model[p[3:0]][i] = 8'hFF;
    for (int i = 0; i < n; i++) begin
      model[p[3:0]][cc] = data_buf[i];
      cc = cc + 4'd1;
    end
  endtask

  task automatic read_page(input logic [7:0] c, input logic [7:0] p, input int n, input string tag);
    logic [7:0] v;
    logic       oe;
    logic [3:0] cc;
    cmd(8'h00); addr(c); addr(p);
    wait_ready();
    check({tag, "_t_r"}, last_busy, 8);
    cc = c[3:0];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model[p[3:0]][cc]);
      cc = cc + 4'd1;
    end
    for (int i = 0; i < n; i++) begin
      ren_pulse(v, oe);
      if (i == 0) check({tag, "_oe"}, oe, 1);
      check($sformatf("%s_b%0d", tag, i), v, exp_q.pop_front());
    end
  endtask

  task automatic status_read(input logic [7:0] exp, input string tag);
    logic [7:0] v;
    logic       oe;
    exp_q.push_back(exp);
    ren_pulse(v, oe);
    check({tag, "_oe"}, oe, 1);
    check(tag, v, exp_q.pop_front());
    check({tag, "_oe_off"}, F_IO_OE, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    logic       oe;
    int         n;

    rst = 1'b1;
    F_IO_IN = 8'h00; F_CLE = 1'b0; F_ALE = 1'b0; F_REN = 1'b1; F_WEN = 1'b1;
`ifdef NAND_WRITE_PROTECT_EN
    F_WPN = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_rb", F_RB, 1);
    check("rst_oe", F_IO_OE, 0);
    check("rst_out", F_IO_OUT, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Status while idle.
    cmd(8'h70);
    status_read(8'hC0, "status_idle");

    // Program page 3 with A0..AF, check the program busy length.
    for (int i = 0; i < 16; i++) data_buf[i] = 8'hA0 + 8'(i);
    program_load(8'h00, 8'h03, 16);
    cmd(8'h10);
    wait_ready();
    check("t_prog", last_busy, 20);
    commit_model(8'h00, 8'h03, 16);

    read_page(8'h00, 8'h03, 16, "rd_p3");
    read_page(8'h0E, 8'h03, 3, "rd_wrap");

    // Reset command during program busy: exactly T_RST clocks after the
    // command clears the two-flop synchroniser, and no commit.
    for (int i = 0; i < 16; i++) data_buf[i] = 8'($urandom_range(0, 255));
    program_load(8'h00, 8'h03, 16);
    cmd(8'h10);
    @(negedge clk);
    F_CLE = 1'b1; F_IO_IN = 8'hFF; F_WEN = 1'b0;
    repeat (3) @(negedge clk);
    F_WEN = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (F_RB) break;
      n++;
    end
    F_CLE = 1'b0;
    check("ff_busy_len", n, 2 + 4);
    repeat (3) @(negedge clk);
    read_page(8'h00, 8'h03, 16, "rd_after_ff");

    // Asynchronous reset in the middle of program busy.
    for (int i = 0; i < 16; i++) data_buf[i] = 8'($urandom_range(0, 255));
    program_load(8'h00, 8'h03, 16);
    cmd(8'h10);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", F_RB, 0);
    rst = 1'b1;
    #1;
    check("rst_mid_rb", F_RB, 1);
    check("rst_mid_oe", F_IO_OE, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    read_page(8'h00, 8'h03, 16, "rd_after_rst");

    // Status command while busy is ignored.
    for (int i = 0; i < 16; i++) data_buf[i] = 8'($urandom_range(0, 255));
    program_load(8'h00, 8'h04, 16);
    cmd(8'h10);
    cmd(8'h70);
    check("status_busy_rb", F_RB, 0);
    wait_ready();
    check("status_busy_len", last_busy, 20);
    commit_model(8'h00, 8'h04, 16);
    ren_pulse(v, oe);
    check("status_ignored_oe", oe, 0);
    read_page(8'h00, 8'h04, 16, "rd_p4");

    // Unknown opcode, then REN outside DOUT/STATUS.
    cmd(8'h5A);
    ren_pulse(v, oe);
    check("unknown_oe", oe, 0);

    // Extra data bytes wrap over column 0.
    for (int i = 0; i < 18; i++) data_buf[i] = 8'($urandom_range(0, 255));
    program_load(8'h00, 8'h06, 18);
    cmd(8'h10);
    wait_ready();
    commit_model(8'h00, 8'h06, 18);
    read_page(8'h00, 8'h06, 16, "rd_overrun");

    // Address truncation: column 12h -> 2, page 27h -> 7; partial fill.
    for (int i = 0; i < 5; i++) data_buf[i] = 8'($urandom_range(0, 255));
    program_load(8'h12, 8'h27, 5);
    cmd(8'h10);
    wait_ready();
    commit_model(8'h12, 8'h27, 5);
    read_page(8'h10, 8'h17, 16, "rd_trunc");

`ifdef NAND_WRITE_PROTECT_EN
    for (int i = 0; i < 16; i++) data_buf[i] = 8'($urandom_range(0, 255));
    program_load(8'h00, 8'h05, 16);
    cmd(8'h10);
    wait_ready();
    commit_model(8'h00, 8'h05, 16);
    for (int i = 0; i < 16; i++) data_buf[i] = 8'h55;
    F_WPN = 1'b0;
    program_load(8'h00, 8'h05, 16);
    cmd(8'h10);
    wait_ready();
    check("wp_busy_len", last_busy, 20);
    cmd(8'h70);
    status_read(8'h41, "wp_status");
    read_page(8'h00, 8'h05, 16, "rd_wp");
    F_WPN = 1'b1;
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
